ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage RV32I core.
- Captures decoded fields from ID and resolves RAW hazards by forwarding from MEM and WB.
- Drives Operand1, Operand2 and AluContrl directly into the ALU.
- Detects load-use hazards, requests an IF/ID freeze and inserts a bubble.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1_data  in  XLEN  register-file read port 1
id_rs2_data  in  XLEN  register-file read port 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  REG_ADDR_W  source register 1 index
id_rs2  in  REG_ADDR_W  source register 2 index
id_rd  in  REG_ADDR_W  destination register index
id_alu_ctrl  in  4  ALU opcode (`ADD, `SUB, ... `LUI)
id_src1_sel  in  1  0 = rs1, 1 = PC
id_src2_sel  in  1  0 = rs2, 1 = imm
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_reg_write  in  1  writes rd
id_mem_read  in  1  load
id_mem_write  in  1  store
mem_rd  in  REG_ADDR_W  MEM-stage destination
mem_reg_write  in  1  MEM-stage writes rd
mem_fwd_data  in  XLEN  MEM-stage ALU result
wb_rd  in  REG_ADDR_W  WB-stage destination
wb_reg_write  in  1  WB-stage writes rd
wb_data  in  XLEN  WB write-back value
stall_in  in  1  downstream busy; hold EX contents
flush  in  1  branch/jump resolved taken; kill EX
Operand1  out  XLEN  ALU operand 1
Operand2  out  XLEN  ALU operand 2
AluContrl  out  4  registered ALU opcode
ex_valid  out  1  EX slot holds a real instruction
ex_pc  out  XLEN  registered PC
ex_rd  out  REG_ADDR_W  registered rd
ex_reg_write  out  1  qualified by ex_valid
ex_mem_read  out  1  qualified by ex_valid
ex_mem_write  out  1  qualified by ex_valid
ex_store_data  out  XLEN  forwarded rs2 value for stores
load_use_stall  out  1  freeze PC and IF/ID this cycle

Behaviour:
- Reset (async, rst_n = 0): all internal registers clear to 0, including ex_valid and AluContrl = 4'd0. Resulting outputs: ex_valid/ex_reg_write/ex_mem_read/ex_mem_write/load_use_stall = 0; Operand1/Operand2/ex_store_data = 0.
- Latency: ID fields appear on EX outputs 1 cycle after capture.
- Register update, priority highest first, evaluated each rising edge:
  1. flush: ex_valid <= 0. Other fields are don't-care; they are cleared to 0.
  2. stall_in: hold all fields. rs1/rs2 data registers are refreshed with their current forwarded values, so a WB producer retiring during the stall is not lost.
  3. load_use_stall: bubble; ex_valid <= 0 and ID is not consumed.
  4. Otherwise: capture all ID fields; ex_valid <= id_valid.
- Load-use detection is combinational:
  - load_use_stall = ex_valid & ex_mem_read & ex_rd != 0 & id_valid & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
  - It is forced to 0 while flush = 1.
  - While stall_in = 1 it is still reported, but the hold rule (priority 2) wins.
- Forwarding per source, combinational on the registered index and data:
  - MEM match (mem_reg_write & mem_rd == rs & rs != 0) selects mem_fwd_data.
  - Else WB match selects wb_data.
  - Else the registered register-file data is used.
  - MEM has priority over WB. x0 is never forwarded.
- Operand1 = src1_sel ? ex_pc : fwd_rs1. Operand2 = src2_sel ? ex_imm : fwd_rs2. ex_store_data = fwd_rs2 always.
- Invalid slots: all side-effect outputs are forced to 0 when ex_valid = 0. Operand values are don't-care but deterministic.

Decomposition:
- Parameters.v: ALU opcode defines (already shared); add SRC1_REG/SRC1_PC, SRC2_REG/SRC2_IMM and FWD_NONE/FWD_MEM/FWD_WB encodings.
- One sub-module, fwd_mux, instantiated twice (rs1, rs2). Inputs: index, registered data, MEM/WB bypass signals. Outputs: value and 2-bit select.

Test Plan:
- Reset mid-operation: assert rst_n = 0 with ex_valid = 1 between edges -> outputs clear immediately, with no clock edge needed.
- Back-to-back RAW: add x5 (MEM, mem_fwd_data = 0x10), add x6 from x5 in EX with register-file data stale 0x0 -> Operand1 = 0x10. Same x5 also in WB with 0x20 -> still 0x10 (MEM wins).
- x0 guard: mem_rd = 0, mem_reg_write = 1, mem_fwd_data = 0xDEAD, EX rs1 = 0, register-file data 0 -> Operand1 = 0.
- Load-use: lw x7 in EX, ID add x8 = x7 + x1 -> load_use_stall = 1 one cycle. Next cycle ex_valid = 0 (bubble). Following cycle the add is captured, and the WB forward of the load value 0x55 appears on Operand1.
- Stall refresh: stall_in = 1 for 3 cycles while the producer of rs2 (value 0x99) passes WB in cycle 1 -> after release Operand2 = ex_store_data = 0x99.
- Flush vs stall: flush = 1 and stall_in = 1 together -> ex_valid = 0 next edge. auipc captured with src1_sel = 1, imm = 0x1000 on PC 0x80 -> Operand1 = 0x80, Operand2 = 0x1000.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// Shared encodings for the ID/EX operand stage: ALU opcodes, operand-source
// selects and forwarding-path selects.
package ex_operand_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic SRC1_REG = 1'b0;
  localparam logic SRC1_PC  = 1'b1;
  localparam logic SRC2_REG = 1'b0;
  localparam logic SRC2_IMM = 1'b1;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  // A later stage may bypass a source only if it writes, targets that source,
  // and the source is not x0.
  function automatic logic fwd_hit(input logic wr_en, input logic idx_eq,
                                   input logic src_nonzero);
    return wr_en & idx_eq & src_nonzero;
  endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-source bypass selector: MEM result beats WB result beats the value
// latched from the register file.
module fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [XLEN-1:0]       i_rf_data,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_reg_write,
  input  logic [XLEN-1:0]       i_mem_data,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_reg_write,
  input  logic [XLEN-1:0]       i_wb_data,
  output logic [XLEN-1:0]       o_value,
  output fwd_sel_t              o_sel
);

  logic w_rs_nz;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_rs_nz   = |i_rs;
  assign w_mem_hit = fwd_hit(i_mem_reg_write, i_mem_rd == i_rs, w_rs_nz);
  assign w_wb_hit  = fwd_hit(i_wb_reg_write, i_wb_rd == i_rs, w_rs_nz);

  always_comb begin
    o_sel   = FWD_NONE;
    o_value = i_rf_data;
    if (w_mem_hit) begin
      o_sel   = FWD_MEM;
      o_value = i_mem_data;
    end else if (w_wb_hit) begin
      o_sel   = FWD_WB;
      o_value = i_wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding into the ALU and
// load-use hazard detection (IF/ID freeze plus EX bubble).
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [3:0]            id_alu_ctrl,
  input  logic                  id_src1_sel,
  input  logic                  id_src2_sel,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [XLEN-1:0]       mem_fwd_data,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic [XLEN-1:0]       Operand1,
  output logic [XLEN-1:0]       Operand2,
  output logic [3:0]            AluContrl,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [XLEN-1:0]       ex_store_data,
  output logic                  load_use_stall
);

  logic                  r_valid;
  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [XLEN-1:0]       r_imm;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [3:0]            r_alu_ctrl;
  logic                  r_src1_sel;
  logic                  r_src2_sel;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;

  logic [XLEN-1:0]       w_fwd1_val;
  logic [XLEN-1:0]       w_fwd2_val;
  fwd_sel_t              w_fwd1_sel;
  fwd_sel_t              w_fwd2_sel;
  logic                  w_rs1_dep;
  logic                  w_rs2_dep;
  logic                  w_load_use;

  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .i_rs            (r_rs1),
    .i_rf_data       (r_rs1_data),
    .i_mem_rd        (mem_rd),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_data      (mem_fwd_data),
    .i_wb_rd         (wb_rd),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_data       (wb_data),
    .o_value         (w_fwd1_val),
    .o_sel           (w_fwd1_sel)
  );

  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .i_rs            (r_rs2),
    .i_rf_data       (r_rs2_data),
    .i_mem_rd        (mem_rd),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_data      (mem_fwd_data),
    .i_wb_rd         (wb_rd),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_data       (wb_data),
    .o_value         (w_fwd2_val),
    .o_sel           (w_fwd2_sel)
  );

  // A load in EX cannot supply its data until WB, so a dependent ID
  // instruction must wait one cycle.
  assign w_rs1_dep  = id_use_rs1 & (id_rs1 == r_rd);
  assign w_rs2_dep  = id_use_rs2 & (id_rs2 == r_rd);
  assign w_load_use = ~flush & r_valid & r_mem_read & (|r_rd) & id_valid &
                      (w_rs1_dep | w_rs2_dep);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_alu_ctrl  <= 4'd0;
      r_src1_sel  <= SRC1_REG;
      r_src2_sel  <= SRC2_REG;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_alu_ctrl  <= 4'd0;
      r_src1_sel  <= SRC1_REG;
      r_src2_sel  <= SRC2_REG;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (stall_in) begin
      // Absorb any bypass seen while held so a producer leaving WB mid-stall
      // is not lost once it retires.
      if (w_fwd1_sel != FWD_NONE) r_rs1_data <= w_fwd1_val;
      if (w_fwd2_sel != FWD_NONE) r_rs2_data <= w_fwd2_val;
    end else if (w_load_use) begin
      r_valid <= 1'b0;
    end else begin
      r_valid     <= id_valid;
      r_pc        <= id_pc;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_imm       <= id_imm;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rd        <= id_rd;
      r_alu_ctrl  <= id_alu_ctrl;
      r_src1_sel  <= id_src1_sel;
      r_src2_sel  <= id_src2_sel;
      r_reg_write <= id_reg_write;
      r_mem_read  <= id_mem_read;
      r_mem_write <= id_mem_write;
    end
  end

  assign Operand1       = (r_src1_sel == SRC1_PC)  ? r_pc  : w_fwd1_val;
  assign Operand2       = (r_src2_sel == SRC2_IMM) ? r_imm : w_fwd2_val;
  assign ex_store_data  = w_fwd2_val;
  assign AluContrl      = r_alu_ctrl;
  assign ex_valid       = r_valid;
  assign ex_pc          = r_pc;
  assign ex_rd          = r_rd;
  assign ex_reg_write   = r_valid & r_reg_write;
  assign ex_mem_read    = r_valid & r_mem_read;
  assign ex_mem_write   = r_valid & r_mem_write;
  assign load_use_stall = w_load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed hazard scenarios plus randomized
// traffic checked against an abstract model of the EX slot.
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_src1_sel, id_src2_sel, id_use_rs1, id_use_rs2;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_fwd_data, wb_data;
  logic        stall_in, flush;
  logic [31:0] Operand1, Operand2, ex_pc, ex_store_data;
  logic [3:0]  AluContrl;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
    .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_fwd_data(mem_fwd_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .stall_in(stall_in), .flush(flush),
    .Operand1(Operand1), .Operand2(Operand2), .AluContrl(AluContrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
    .load_use_stall(load_use_stall)
  );

  // Abstract content of the EX slot
  typedef struct {
    bit          valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    bit          use_pc, use_imm, wr, ld, st;
  } slot_t;

  slot_t m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_ctrl = ALU_ADD;
    id_src1_sel = 0; id_src2_sel = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    mem_rd = 0; mem_reg_write = 0; mem_fwd_data = 0;
    wb_rd = 0; wb_reg_write = 0; wb_data = 0;
    stall_in = 0; flush = 0;
  endtask

  function automatic logic [31:0] model_src(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return rf;
    if (mem_reg_write && mem_rd == idx) return mem_fwd_data;
    if (wb_reg_write && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  function automatic bit model_hazard();
    if (flush || !m.valid || !m.ld || m.rd == 0 || !id_valid) return 0;
    return (id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd);
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    n_checks++; if (AluContrl !== 4'd0) begin n_fail++; $display("FAIL reset_alu: got %h want 0", AluContrl); end
    n_checks++; if ({Operand1, Operand2, ex_store_data} !== 96'd0) begin n_fail++; $display("FAIL reset_operands: got %h %h %h want 0", Operand1, Operand2, ex_store_data); end
    n_checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall}); end
    #10 rst_n = 1;
    tick();
    // capture a live instruction, then reset between edges
    id_valid = 1; id_pc = 32'h44; id_src1_sel = 1; id_rs2_data = 32'h1234;
    id_reg_write = 1; id_rd = 3; id_alu_ctrl = ALU_SUB;
    tick();
    idle_inputs();
    #1;
    n_checks++; if (ex_valid !== 1'b1 || Operand1 !== 32'h44) begin n_fail++; $display("FAIL pre_reset_capture: got v=%b op1=%h want 1 44", ex_valid, Operand1); end
    rst_n = 0;
    #1;
    n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b%b want 00", ex_valid, ex_reg_write); end
    n_checks++; if (Operand1 !== 0 || Operand2 !== 0 || AluContrl !== 0) begin n_fail++; $display("FAIL async_reset_data: got %h %h %h want 0", Operand1, Operand2, AluContrl); end
    #1 rst_n = 1;
    tick();
  endtask

  task automatic test_raw_forward();
    idle_inputs();
    id_valid = 1; id_rs1 = 5; id_rs1_data = 0; id_use_rs1 = 1; id_rd = 6;
    id_reg_write = 1; id_rs2 = 7; id_rs2_data = 32'h3; id_use_rs2 = 1;
    tick();
    idle_inputs();
    mem_rd = 5; mem_reg_write = 1; mem_fwd_data = 32'h10;
    #1;
    n_checks++; if (Operand1 !== 32'h10) begin n_fail++; $display("FAIL raw_mem: got %h want 10", Operand1); end
    wb_rd = 5; wb_reg_write = 1; wb_data = 32'h20;
    #1;
    n_checks++; if (Operand1 !== 32'h10) begin n_fail++; $display("FAIL raw_mem_over_wb: got %h want 10", Operand1); end
    mem_reg_write = 0;
    #1;
    n_checks++; if (Operand1 !== 32'h20) begin n_fail++; $display("FAIL raw_wb: got %h want 20", Operand1); end
    n_checks++; if (Operand2 !== 32'h3) begin n_fail++; $display("FAIL raw_no_fwd: got %h want 3", Operand2); end
    tick();
  endtask

  task automatic test_x0_guard();
    idle_inputs();
    id_valid = 1; id_rs1 = 0; id_rs1_data = 0; id_use_rs1 = 1; id_rd = 4;
    tick();
    idle_inputs();
    mem_rd = 0; mem_reg_write = 1; mem_fwd_data = 32'hDEAD;
    wb_rd = 0; wb_reg_write = 1; wb_data = 32'hBEEF;
    #1;
    n_checks++; if (Operand1 !== 32'h0) begin n_fail++; $display("FAIL x0_guard: got %h want 0", Operand1); end
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    id_valid = 1; id_rd = 7; id_rs1 = 2; id_use_rs1 = 1; id_mem_read = 1;
    id_reg_write = 1; id_src2_sel = 1; id_imm = 32'h8;
    tick();
    idle_inputs();
    id_valid = 1; id_rd = 8; id_rs1 = 7; id_rs2 = 1; id_use_rs1 = 1;
    id_use_rs2 = 1; id_rs1_data = 0; id_rs2_data = 32'h3; id_reg_write = 1;
    #1;
    n_checks++; if (load_use_stall !== 1'b1) begin n_fail++; $display("FAIL load_use_detect: got %b want 1", load_use_stall); end
    n_checks++; if (ex_mem_read !== 1'b1) begin n_fail++; $display("FAIL load_in_ex: got %b want 1", ex_mem_read); end
    tick();
    #1;
    n_checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL load_use_bubble: got %b%b want 00", ex_valid, ex_reg_write); end
    n_checks++; if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL load_use_one_cycle: got %b want 0", load_use_stall); end
    tick();
    id_valid = 0;
    wb_rd = 7; wb_reg_write = 1; wb_data = 32'h55;
    #1;
    n_checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd8) begin n_fail++; $display("FAIL load_use_capture: got v=%b rd=%0d want 1 8", ex_valid, ex_rd); end
    n_checks++; if (Operand1 !== 32'h55 || Operand2 !== 32'h3) begin n_fail++; $display("FAIL load_use_wb_fwd: got %h %h want 55 3", Operand1, Operand2); end
    tick();
  endtask

  task automatic test_stall_refresh();
    idle_inputs();
    id_valid = 1; id_rs1 = 0; id_rs2 = 9; id_use_rs2 = 1; id_rs2_data = 0;
    id_mem_write = 1; id_pc = 32'h100;
    tick();
    idle_inputs();
    id_valid = 1; id_rd = 12; id_pc = 32'h104;
    stall_in = 1;
    wb_rd = 9; wb_reg_write = 1; wb_data = 32'h99;
    tick();
    wb_reg_write = 0; wb_data = 0;
    tick();
    tick();
    n_checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100) begin n_fail++; $display("FAIL stall_hold: got v=%b pc=%h want 1 100", ex_valid, ex_pc); end
    stall_in = 0; id_valid = 0;
    #1;
    n_checks++; if (Operand2 !== 32'h99 || ex_store_data !== 32'h99) begin n_fail++; $display("FAIL stall_refresh: got %h %h want 99 99", Operand2, ex_store_data); end
    n_checks++; if (ex_mem_write !== 1'b1) begin n_fail++; $display("FAIL stall_store_kept: got %b want 1", ex_mem_write); end
    tick();
  endtask

  task automatic test_flush_vs_stall();
    idle_inputs();
    id_valid = 1; id_rd = 7; id_mem_read = 1; id_reg_write = 1;
    tick();
    idle_inputs();
    id_valid = 1; id_rs1 = 7; id_use_rs1 = 1; id_rd = 9;
    flush = 1; stall_in = 1;
    #1;
    n_checks++; if (load_use_stall !== 1'b0) begin n_fail++; $display("FAIL flush_masks_hazard: got %b want 0", load_use_stall); end
    tick();
    n_checks++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin n_fail++; $display("FAIL flush_over_stall: got %b%b%b want 000", ex_valid, ex_mem_read, ex_reg_write); end
    idle_inputs();
    id_valid = 1; id_pc = 32'h80; id_src1_sel = 1; id_src2_sel = 1;
    id_imm = 32'h1000; id_rd = 3; id_reg_write = 1; id_alu_ctrl = ALU_ADD;
    tick();
    idle_inputs();
    #1;
    n_checks++; if (Operand1 !== 32'h80 || Operand2 !== 32'h1000) begin n_fail++; $display("FAIL auipc_operands: got %h %h want 80 1000", Operand1, Operand2); end
    n_checks++; if (ex_reg_write !== 1'b1 || ex_rd !== 5'd3) begin n_fail++; $display("FAIL auipc_ctrl: got w=%b rd=%0d want 1 3", ex_reg_write, ex_rd); end
    tick();
  endtask

  task automatic test_random();
    bit exp_lus;
    // flush the slot so the model starts from a known empty state
    idle_inputs();
    flush = 1;
    tick();
    m = '{valid: 0, pc: 0, a: 0, b: 0, imm: 0, rs1: 0, rs2: 0, rd: 0, alu: 0,
          use_pc: 0, use_imm: 0, wr: 0, ld: 0, st: 0};
    for (int cyc = 0; cyc < 400; cyc++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3)); id_alu_ctrl = 4'($urandom_range(0, 10));
      id_src1_sel = 1'($urandom); id_src2_sel = 1'($urandom);
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom);
      mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom); mem_fwd_data = $urandom;
      wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom); wb_data = $urandom;
      stall_in = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      #1;
      exp_lus = model_hazard();
      n_checks++; if (load_use_stall !== exp_lus) begin n_fail++; $display("FAIL rnd_load_use cyc %0d: got %b want %b", cyc, load_use_stall, exp_lus); end
      n_checks++; if (ex_valid !== m.valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d: got %b want %b", cyc, ex_valid, m.valid); end
      n_checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write} !== {m.valid & m.wr, m.valid & m.ld, m.valid & m.st}) begin n_fail++; $display("FAIL rnd_side_effects cyc %0d: got %b%b%b", cyc, ex_reg_write, ex_mem_read, ex_mem_write); end
      if (m.valid) begin
        n_checks++; if (Operand1 !== (m.use_pc ? m.pc : model_src(m.rs1, m.a))) begin n_fail++; $display("FAIL rnd_op1 cyc %0d: got %h want %h", cyc, Operand1, m.use_pc ? m.pc : model_src(m.rs1, m.a)); end
        n_checks++; if (Operand2 !== (m.use_imm ? m.imm : model_src(m.rs2, m.b))) begin n_fail++; $display("FAIL rnd_op2 cyc %0d: got %h want %h", cyc, Operand2, m.use_imm ? m.imm : model_src(m.rs2, m.b)); end
        n_checks++; if (ex_store_data !== model_src(m.rs2, m.b)) begin n_fail++; $display("FAIL rnd_store cyc %0d: got %h want %h", cyc, ex_store_data, model_src(m.rs2, m.b)); end
        n_checks++; if (AluContrl !== m.alu || ex_rd !== m.rd || ex_pc !== m.pc) begin n_fail++; $display("FAIL rnd_fields cyc %0d: got %h %0d %h want %h %0d %h", cyc, AluContrl, ex_rd, ex_pc, m.alu, m.rd, m.pc); end
      end
      // next slot content from this cycle's inputs
      if (flush) begin
        m.valid = 0;
      end else if (stall_in) begin
        m.a = model_src(m.rs1, m.a);
        m.b = model_src(m.rs2, m.b);
      end else if (exp_lus) begin
        m.valid = 0;
      end else begin
        m = '{valid: id_valid, pc: id_pc, a: id_rs1_data, b: id_rs2_data, imm: id_imm,
              rs1: id_rs1, rs2: id_rs2, rd: id_rd, alu: id_alu_ctrl,
              use_pc: id_src1_sel, use_imm: id_src2_sel, wr: id_reg_write,
              ld: id_mem_read, st: id_mem_write};
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_raw_forward();
    test_x0_guard();
    test_load_use();
    test_stall_refresh();
    test_flush_vs_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
